// File: rtl/vector_stack.sv
// LIFO of activation vectors for the backprop path: push/pop in IDLE, full-stack drain
// in reverse order followed by size-1 zero flush cycles, plus the skew-stage burst marker.
module vector_stack #(
   parameter int unsigned data_size = 16,
   parameter int unsigned size      = 3,
   parameter int unsigned depth     = 8
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             push,
   input  logic [data_size*size-1:0]        push_data,
   input  logic                             pop,
   input  logic                             drain,
   output logic [data_size*size-1:0]        out_data,
   output logic                             out_valid,
   output logic                             reset_counter,
   output logic                             busy,
   output logic [$clog2(depth+1)-1:0]       count,
   output logic                             full,
   output logic                             empty,
   output logic                             overflow,
   output logic                             underflow
);

   localparam int unsigned W  = data_size * size;
   localparam int unsigned CW = $clog2(depth + 1);
   localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
   localparam int unsigned FW = (size > 1) ? $clog2(size) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_e;

   state_e          state_q, state_d;
   logic [FW-1:0]   flush_q, flush_d;
   logic [CW-1:0]   count_q, count_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            rc_q, rc_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;

   logic [W-1:0]    mem_q [depth];
   logic            wr_en;
   logic [AW-1:0]   wr_idx;
   logic [AW-1:0]   top_idx;

   assign top_idx = AW'(count_q - CW'(1));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         flush_q     <= '0;
         count_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         rc_q        <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_q     <= flush_d;
         count_q     <= count_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         rc_q        <= rc_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   // Storage needs no reset: contents are only read below the top pointer.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= push_data;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      flush_d = flush_q;
      case (state_q)
         S_IDLE: begin
            if (drain) begin
               flush_d = '0;
               if (count_q != '0)  state_d = S_DRAIN;
               else if (size > 1)  state_d = S_FLUSH;
            end
         end
         S_DRAIN: begin
            if (count_q == CW'(1)) begin
               flush_d = '0;
               state_d = (size > 1) ? S_FLUSH : S_IDLE;
            end
         end
         S_FLUSH: begin
            if (flush_q == FW'(size - 2)) state_d = S_IDLE;
            else                          flush_d = flush_q + FW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath / output control
   always_comb begin
      count_d     = count_q;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      wr_en       = 1'b0;
      wr_idx      = AW'(count_q);
      case (state_q)
         S_IDLE: begin
            if (drain) begin
               if (push) ovf_d = 1'b1;
            end else if (pop && count_q != '0) begin
               out_data_d  = mem_q[top_idx];
               out_valid_d = 1'b1;
               // Simultaneous push replaces the popped top in place.
               if (push) begin
                  wr_en  = 1'b1;
                  wr_idx = top_idx;
               end else begin
                  count_d = count_q - CW'(1);
               end
            end else begin
               if (pop) unf_d = 1'b1;
               if (push) begin
                  if (count_q != CW'(depth)) begin
                     wr_en   = 1'b1;
                     count_d = count_q + CW'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
         end
         S_DRAIN: begin
            out_data_d  = mem_q[top_idx];
            out_valid_d = 1'b1;
            count_d     = count_q - CW'(1);
            if (push) ovf_d = 1'b1;
         end
         S_FLUSH: begin
            if (push) ovf_d = 1'b1;
         end
         default: ;
      endcase
      rc_d = out_valid_d & ~out_valid_q;
   end

   assign out_data      = out_data_q;
   assign out_valid     = out_valid_q;
   assign reset_counter = rc_q;
   assign busy          = (state_q != S_IDLE);
   assign count         = count_q;
   assign full          = (count_q == CW'(depth));
   assign empty         = (count_q == '0);
   assign overflow      = ovf_q;
   assign underflow     = unf_q;

endmodule

// File: tb/tb_vector_stack.sv
// Directed bench for vector_stack (data_size=16, size=3, depth=8).
module tb_vector_stack;

   localparam int unsigned DS = 16;
   localparam int unsigned SZ = 3;
   localparam int unsigned DP = 8;
   localparam int unsigned W  = DS * SZ;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          push, pop, drain;
   logic [W-1:0]  push_data;
   logic [W-1:0]  out_data;
   logic          out_valid, reset_counter, busy, full, empty, overflow, underflow;
   logic [3:0]    count;

   int n_checks = 0;
   int n_fail   = 0;

   vector_stack #(.data_size(DS), .size(SZ), .depth(DP)) dut (
      .clk(clk), .reset_n(reset_n), .push(push), .push_data(push_data),
      .pop(pop), .drain(drain), .out_data(out_data), .out_valid(out_valid),
      .reset_counter(reset_counter), .busy(busy), .count(count), .full(full),
      .empty(empty), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] vec(input int n);
      return {16'(n), 16'(n + 256), 16'(n + 512)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      push = 0; pop = 0; drain = 0; push_data = '0;
      reset_n = 0;
      step();
      step();
      reset_n = 1;
      step();
   endtask

   task automatic test_reset();
      push = 0; pop = 0; drain = 0; push_data = '0;
      reset_n = 0;
      #3;
      n_checks++;
      if ({out_data, out_valid, reset_counter, busy, count, overflow, underflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%h v=%b rc=%b busy=%b cnt=%0d ovf=%b unf=%b, expected all 0",
                  out_data, out_valid, reset_counter, busy, count, overflow, underflow);
      end
      n_checks++;
      if ({empty, full} !== 2'b10) begin
         n_fail++; $display("FAIL reset_flags: got empty=%b full=%b, expected 1 0", empty, full);
      end
      step();
      reset_n = 1;
      step();
   endtask

   task automatic test_push_pop();
      logic [W-1:0] exp_v [3];
      do_reset();
      for (int i = 0; i < 3; i++) begin
         push = 1; push_data = vec(16'hA0 + i);
         step();
      end
      push = 0;
      n_checks++;
      if (count !== 4'd3) begin n_fail++; $display("FAIL pp_count3: got %0d expected 3", count); end
      exp_v[0] = vec(16'hA2); exp_v[1] = vec(16'hA1); exp_v[2] = vec(16'hA0);
      pop = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (out_data !== exp_v[i] || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL pp_pop%0d: got %h v=%b expected %h v=1", i, out_data, out_valid, exp_v[i]);
         end
         n_checks++;
         if (reset_counter !== (i == 0)) begin
            n_fail++; $display("FAIL pp_rc%0d: got %b expected %b", i, reset_counter, i == 0);
         end
         n_checks++;
         if (count !== 4'(2 - i)) begin
            n_fail++; $display("FAIL pp_count%0d: got %0d expected %0d", i, count, 2 - i);
         end
      end
      pop = 0;
      n_checks++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL pp_empty: got %b expected 1", empty); end
      step();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
         n_fail++; $display("FAIL pp_idle_out: got %h v=%b expected 0 v=0", out_data, out_valid);
      end
   endtask

   task automatic test_overflow_drain();
      int k;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         push = 1; push_data = vec(16'h10 + i);
         step();
      end
      n_checks++;
      if (full !== 1'b1 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL ov_full: got full=%b ovf=%b expected 1 0", full, overflow);
      end
      push_data = vec(16'h19);
      step();
      push = 0;
      n_checks++;
      if (overflow !== 1'b1 || count !== 4'd8) begin
         n_fail++; $display("FAIL ov_flag: got ovf=%b cnt=%0d expected 1 8", overflow, count);
      end
      drain = 1;
      step();
      drain = 0;
      step();
      n_checks++;
      if (out_data !== vec(16'h18) || out_valid !== 1'b1 || reset_counter !== 1'b1) begin
         n_fail++; $display("FAIL ov_drain_first: got %h v=%b rc=%b expected %h v=1 rc=1",
                            out_data, out_valid, reset_counter, vec(16'h18));
      end
      k = 0;
      while (busy && k < 30) begin step(); k++; end
      n_checks++;
      if (busy !== 1'b0 || count !== 4'd0) begin
         n_fail++; $display("FAIL ov_drain_end: got busy=%b cnt=%0d expected 0 0", busy, count);
      end
   endtask

   task automatic test_drain5();
      logic          e_busy, e_valid, e_rc;
      logic [W-1:0]  e_data;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push = 1; push_data = vec(16'h30 + i);
         step();
      end
      push = 0;
      drain = 1;
      step();
      drain = 0;
      // k counts cycles after the edge that sampled drain.
      for (int k = 1; k <= 9; k++) begin
         e_busy  = (k <= 7);
         e_valid = (k >= 2 && k <= 6);
         e_rc    = (k == 2);
         e_data  = e_valid ? vec(16'h34 - (k - 2)) : '0;
         n_checks++;
         if (busy !== e_busy || out_valid !== e_valid || reset_counter !== e_rc || out_data !== e_data) begin
            n_fail++;
            $display("FAIL d5_cyc%0d: got busy=%b v=%b rc=%b data=%h expected busy=%b v=%b rc=%b data=%h",
                     k, busy, out_valid, reset_counter, out_data, e_busy, e_valid, e_rc, e_data);
         end
         step();
      end
      n_checks++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL d5_empty: got %b expected 1", empty); end
   endtask

   task automatic test_underflow_pushpop();
      do_reset();
      pop = 1;
      step();
      pop = 0;
      n_checks++;
      if (underflow !== 1'b1 || out_valid !== 1'b0 || count !== 4'd0) begin
         n_fail++; $display("FAIL uf_pop: got unf=%b v=%b cnt=%0d expected 1 0 0", underflow, out_valid, count);
      end
      do_reset();
      push = 1; pop = 1; push_data = vec(16'h40);
      step();
      push = 0; pop = 0;
      n_checks++;
      if (underflow !== 1'b1 || out_valid !== 1'b0 || count !== 4'd1) begin
         n_fail++; $display("FAIL uf_pushpop: got unf=%b v=%b cnt=%0d expected 1 0 1", underflow, out_valid, count);
      end
      do_reset();
      push = 1; push_data = vec(16'h51); step();
      push_data = vec(16'h52); step();
      pop = 1; push_data = vec(16'h53); step();
      push = 0;
      n_checks++;
      if (out_data !== vec(16'h52) || out_valid !== 1'b1 || count !== 4'd2) begin
         n_fail++; $display("FAIL sw_out: got %h v=%b cnt=%0d expected %h v=1 cnt=2",
                            out_data, out_valid, count, vec(16'h52));
      end
      step();
      pop = 0;
      n_checks++;
      if (out_data !== vec(16'h53) || reset_counter !== 1'b0 || count !== 4'd1) begin
         n_fail++; $display("FAIL sw_next: got %h rc=%b cnt=%0d expected %h rc=0 cnt=1",
                            out_data, reset_counter, count, vec(16'h53));
      end
   endtask

   task automatic test_drain_ignore_and_abort();
      logic [W-1:0] exp_v [3];
      int k;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         push = 1; push_data = vec(16'h60 + i);
         step();
      end
      push = 0;
      drain = 1;
      step();
      drain = 0;
      push = 1; pop = 1; push_data = vec(16'h99);
      exp_v[0] = vec(16'h62); exp_v[1] = vec(16'h61); exp_v[2] = vec(16'h60);
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (out_data !== exp_v[i] || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL di_order%0d: got %h v=%b expected %h v=1", i, out_data, out_valid, exp_v[i]);
         end
      end
      push = 0; pop = 0;
      n_checks++;
      if (overflow !== 1'b1 || underflow !== 1'b0 || count !== 4'd0) begin
         n_fail++; $display("FAIL di_flags: got ovf=%b unf=%b cnt=%0d expected 1 0 0", overflow, underflow, count);
      end
      k = 0;
      while (busy && k < 30) begin step(); k++; end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL di_timeout: busy=%b expected 0", busy); end

      do_reset();
      for (int i = 0; i < 4; i++) begin
         push = 1; push_data = vec(16'h70 + i);
         step();
      end
      push = 0;
      drain = 1; step(); drain = 0;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL ab_pre: got v=%b busy=%b expected 1 1", out_valid, busy);
      end
      #2;
      reset_n = 0;
      #1;
      n_checks++;
      if ({out_data, out_valid, reset_counter, busy, count, overflow, underflow} !== '0) begin
         n_fail++; $display("FAIL ab_async: got data=%h v=%b rc=%b busy=%b cnt=%0d expected all 0",
                            out_data, out_valid, reset_counter, busy, count);
      end
      step();
      reset_n = 1;
      step();
      push = 1; push_data = vec(16'h88); step();
      push = 0;
      n_checks++;
      if (count !== 4'd1) begin n_fail++; $display("FAIL ab_push: got cnt=%0d expected 1", count); end
      pop = 1; step(); pop = 0;
      n_checks++;
      if (out_data !== vec(16'h88) || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL ab_pop: got %h v=%b expected %h v=1", out_data, out_valid, vec(16'h88));
      end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_overflow_drain();
      test_drain5();
      test_underflow_pushpop();
      test_drain_ignore_and_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
